fetch_hazard_ctrl: RTL and testbench

Front-end sequencing controller for the five-stage pipeline. It drives the PC write enable, the PC source select and the IF/ID write enable, and flushes the IF/ID, ID/EX and EX/MEM registers. It resolves load-use stalls, taken-branch redirects from MEM, the HALT instruction and debug single-stepping. It also keeps saturating stall and flush performance counters, and sits beside the fetch stage and the ID-stage decoder.

---
 rtl/fetch_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: front-end sequencing controller for the five-stage pipeline.
// Resolves load-use stalls, taken-branch redirects from MEM, HALT and debug
// single-stepping; keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt   source registers of the instruction in ID
//   id_halt                    ID instruction is HALT
//   ex_mem_read, ex_rt         load in EX and its destination register
//   mem_branch_taken           branch in MEM resolved taken
//   dbg_step_mode, dbg_step    single-step mode level / advance pulse
//   pc_write, pc_source        PC enable / select (0 = pc+4, 1 = branch target)
//   if_id_write                IF/ID enable
//   if_id_flush, id_ex_flush,
//   ex_mem_flush               synchronous clears of the pipeline registers
//   halted, state              sequencing state (RUN/STEP_HOLD/STEP_GO/HALTED)
//   stall_cnt, flush_cnt       saturating load-use stall / branch flush counters
module fetch_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             dbg_step_mode,
  input  logic             dbg_step,
  output logic             pc_write,
  output logic             pc_source,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_STEP_HOLD = 2'b01,
    ST_STEP_GO   = 2'b10,
    ST_HALTED    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q;
  state_t state_d;
  logic   load_use_c;
  logic   frozen_c;
  logic   stall_inc_c;
  logic   flush_inc_c;

  // Load in EX writes a register the ID instruction reads; r0 never hazards.
  assign load_use_c = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Front end held while waiting for a debug step or after HALT.
  assign frozen_c = (state_q == ST_STEP_HOLD) || (state_q == ST_HALTED);

  assign halted = (state_q == ST_HALTED);
  assign state  = state_q;

  // Prioritised control decode and next-state selection.
  always_comb begin
    pc_write     = 1'b1;
    pc_source    = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc_c  = 1'b0;
    flush_inc_c  = 1'b0;
    state_d      = state_q;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
    end else if (mem_branch_taken) begin
      // Redirect wins everywhere; a HALT being held was on the wrong path.
      pc_source    = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc_c  = 1'b1;
      if (state_q == ST_HALTED) begin
        state_d = ST_RUN;
      end
    end else begin
      // Frozen, stalled or halting: hold IF/ID and feed a bubble into EX.
      if (frozen_c || load_use_c || id_halt) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      stall_inc_c = !frozen_c && load_use_c;

      unique case (state_q)
        ST_RUN: begin
          if (!load_use_c && id_halt) begin
            state_d = ST_HALTED;
          end else if (dbg_step_mode) begin
            state_d = ST_STEP_HOLD;
          end
        end
        ST_STEP_HOLD: begin
          if (!dbg_step_mode) begin
            state_d = ST_RUN;
          end else if (dbg_step) begin
            state_d = ST_STEP_GO;
          end
        end
        ST_STEP_GO: begin
          // The step is only consumed by a cycle that actually advanced.
          if (!load_use_c && id_halt) begin
            state_d = ST_HALTED;
          end else if (!load_use_c) begin
            state_d = ST_STEP_HOLD;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc_c && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc_c && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed + randomized bench for fetch_hazard_ctrl.
// Two instances (default counter width and a 4-bit counter width) share the
// same stimulus and are compared each cycle against a rule-table model.
module tb_fetch_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             mem_branch_taken;
  logic             dbg_step_mode;
  logic             dbg_step;

  logic        a_pc_write, a_pc_source, a_if_id_write, a_if_id_flush;
  logic        a_id_ex_flush, a_ex_mem_flush, a_halted;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic        b_pc_write, b_pc_source, b_if_id_write, b_if_id_flush;
  logic        b_id_ex_flush, b_ex_mem_flush, b_halted;
  logic [1:0]  b_state;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_vec;
  int n_bad;

  // Model state: 0 RUN, 1 STEP_HOLD, 2 STEP_GO, 3 HALTED.
  int m_state;
  int m_stall16, m_flush16, m_stall4, m_flush4;

  fetch_hazard_ctrl #(.REG_W(REG_W), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .pc_write(a_pc_write), .pc_source(a_pc_source), .if_id_write(a_if_id_write),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .ex_mem_flush(a_ex_mem_flush), .halted(a_halted), .state(a_state),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  fetch_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .pc_write(b_pc_write), .pc_source(b_pc_source), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .ex_mem_flush(b_ex_mem_flush), .halted(b_halted), .state(b_state),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Which priority rule governs the current cycle.
  function automatic int rule_now();
    bit haz;
    haz = ex_mem_read && (ex_rt != 0) &&
          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (reset)                            return 1;
    if (mem_branch_taken)                 return 2;
    if ((m_state == 1) || (m_state == 3)) return 3;
    if (haz)                              return 4;
    if (id_halt)                          return 5;
    return 6;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Compare both instances against the model for the current inputs.
  task automatic check_cycle();
    int r;
    logic [8:0] exp_ctrl, got_a, got_b;
    r = rule_now();
    exp_ctrl = {
      1'((r == 2) || (r == 6)),   // pc_write
      1'(r == 2),                 // pc_source
      1'((r == 2) || (r == 6)),   // if_id_write
      1'(r <= 2),                 // if_id_flush
      1'(r <= 5),                 // id_ex_flush
      1'(r <= 2),                 // ex_mem_flush
      1'(m_state == 3),           // halted
      2'(m_state)
    };
    got_a = {a_pc_write, a_pc_source, a_if_id_write, a_if_id_flush,
             a_id_ex_flush, a_ex_mem_flush, a_halted, a_state};
    got_b = {b_pc_write, b_pc_source, b_if_id_write, b_if_id_flush,
             b_id_ex_flush, b_ex_mem_flush, b_halted, b_state};
    check("ctrl", 32'(got_a), 32'(exp_ctrl));
    check("ctrl_w4", 32'(got_b), 32'(exp_ctrl));
    check("stall_cnt", 32'(a_stall_cnt), 32'(m_stall16));
    check("flush_cnt", 32'(a_flush_cnt), 32'(m_flush16));
    check("stall_cnt_w4", 32'(b_stall_cnt), 32'(m_stall4));
    check("flush_cnt_w4", 32'(b_flush_cnt), 32'(m_flush4));
  endtask

  // Advance the model across the edge using the inputs held before it.
  task automatic model_update();
    int r;
    r = rule_now();
    if (r == 1) begin
      m_state = 0; m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end else if (r == 2) begin
      m_flush16 = sat_inc(m_flush16, 65535);
      m_flush4  = sat_inc(m_flush4, 15);
      if (m_state == 3) m_state = 0;
    end else if (r == 5) begin
      m_state = 3;
    end else begin
      if (r == 4) begin
        m_stall16 = sat_inc(m_stall16, 65535);
        m_stall4  = sat_inc(m_stall4, 15);
      end
      case (m_state)
        0: if (dbg_step_mode) m_state = 1;
        1: if (!dbg_step_mode) m_state = 0; else if (dbg_step) m_state = 2;
        2: if (r == 6) m_state = 1;
        default: m_state = 3;
      endcase
    end
  endtask

  // One cycle: inputs already applied; check, take the edge, update model.
  task automatic cycle();
    #1;
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_halt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; mem_branch_taken = 1'b0;
    dbg_step_mode = 1'b0; dbg_step = 1'b0;
  endtask

  task automatic set_hazard(input bit on);
    ex_mem_read = on; ex_rt = on ? 5'd5 : 5'd0; id_rs = on ? 5'd5 : 5'd0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_state = 0; m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    cycle();                       // reset still high: all flushes, no pc_write

    // Load-use stall, then a load to r0 which must not stall.
    idle_inputs();
    set_hazard(1'b1);
    cycle();
    set_hazard(1'b0);
    ex_mem_read = 1'b1;
    cycle();
    check("stall_after_one", 32'(a_stall_cnt), 32'd1);

    // Branch together with a hazard counts only as a flush.
    set_hazard(1'b1);
    mem_branch_taken = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check("flush_after_branch", 32'(a_flush_cnt), 32'd1);
    check("stall_unchanged", 32'(a_stall_cnt), 32'd1);

    // HALT, hold for 10 cycles, then release by a wrong-path branch.
    id_halt = 1'b1;
    cycle();
    id_halt = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("halted_state", 32'(a_state), 32'd3);
    mem_branch_taken = 1'b1;
    cycle();
    mem_branch_taken = 1'b0;
    cycle();
    check("run_after_branch", 32'(a_state), 32'd0);

    // Single-step: one advance per pulse, held across a load-use stall.
    dbg_step_mode = 1'b1;
    cycle();
    cycle();
    dbg_step = 1'b1;
    cycle();
    dbg_step = 1'b0;
    cycle();                       // STEP_GO advances once
    cycle();
    set_hazard(1'b1);
    dbg_step = 1'b1;
    cycle();
    dbg_step = 1'b0;
    cycle();
    cycle();
    check("go_held_by_stall", 32'(a_state), 32'd2);
    set_hazard(1'b0);
    cycle();
    cycle();
    check("back_to_hold", 32'(a_state), 32'd1);

    // Reset while in STEP_GO with nonzero counters.
    set_hazard(1'b1);
    dbg_step = 1'b1;
    cycle();
    dbg_step = 1'b0;
    reset = 1'b1;
    cycle();
    check("reset_state", 32'(a_state), 32'd0);
    check("reset_stall", 32'(a_stall_cnt), 32'd0);
    idle_inputs();

    // Saturation of the 4-bit stall counter.
    set_hazard(1'b1);
    for (int i = 0; i < 20; i++) cycle();
    check("stall_sat_w4", 32'(b_stall_cnt), 32'd15);
    check("stall_w16", 32'(a_stall_cnt), 32'd20);
    idle_inputs();
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      reset            = ($urandom % 64) == 0;
      id_rs            = 5'($urandom % 4);
      id_rt            = 5'($urandom % 4);
      id_uses_rt       = 1'($urandom % 2);
      id_halt          = ($urandom % 12) == 0;
      ex_mem_read      = 1'($urandom % 2);
      ex_rt            = 5'($urandom % 4);
      mem_branch_taken = ($urandom % 6) == 0;
      if (($urandom % 16) == 0) dbg_step_mode = ~dbg_step_mode;
      dbg_step         = ($urandom % 4) == 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
